// File: rtl/alu_pkg.sv
// Shared types and constants for the start/done ALU.
package alu_pkg;

    // Opcode encoding. 101-111 are reserved and behave like NOP.
    typedef enum logic [2:0] {
        NOP = 3'b000,
        ADD = 3'b001,
        AND = 3'b010,
        XOR = 3'b011,
        MUL = 3'b100
    } op_e;

    // Controller states: idle/accepting, or waiting on the multiplier pipe.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    localparam int MUL_LAT_DEFAULT = 3;

    // Result of every opcode that completes one cycle after accept.
    // NOP, MUL (never routed here) and reserved codes yield zero.
    function automatic logic [15:0] alu_single(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [2:0] op);
        logic [15:0] r;
        r = 16'h0000;
        case (op_e'(op))
            ADD:     r = {7'b0, {1'b0, a} + {1'b0, b}};
            AND:     r = {8'h00, a & b};
            XOR:     r = {8'h00, a ^ b};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/modport_alu_mul.sv
// 8x8 unsigned multiplier, MUL_LAT-1 register stages in total:
// one operand-capture stage (loaded on ld) followed by MUL_LAT-2 product
// stages that advance on en. With MUL_LAT=2 the product is combinational
// from the captured operands.
module modport_alu_mul
    import alu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld,
    input  logic        en,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    localparam int PSTG = MUL_LAT - 2;

    logic [7:0] a_q, b_q;

    // Operand capture; only touched on accept so later input changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= 8'h00;
            b_q <= 8'h00;
        end else if (ld) begin
            a_q <= a;
            b_q <= b;
        end
    end

    generate
        if (PSTG == 0) begin : g_comb
            assign product = 16'(a_q) * 16'(b_q);
        end else begin : g_pipe
            logic [PSTG-1:0][15:0] pipe_q;

            // Product shift pipe, advanced only while the controller is in MUL.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pipe_q <= '0;
                end else if (en) begin
                    pipe_q[0] <= 16'(a_q) * 16'(b_q);
                    for (int i = 1; i < PSTG; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign product = pipe_q[PSTG-1];
        end
    endgenerate

endmodule

// File: rtl/modport_alu.sv
// 8-bit ALU with start/done handshake. Single-cycle ops finish one cycle
// after accept; multiply finishes MUL_LAT cycles after accept. An arm flag
// stops a start that is still held after done from re-triggering.
// MUL_LAT must be >= 2.
module modport_alu
    import alu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
);

    // Counter holds 0..MUL_LAT-2 while in MUL; last value ends the op.
    localparam int                CW       = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(MUL_LAT - 2);

    state_e        state_q, state_d;
    logic          armed_q;
    logic [CW-1:0] cnt_q;
    logic          accept;
    logic          is_mul;
    logic          mul_last;
    logic [15:0]   product;

    assign accept = (state_q == S_IDLE) && armed_q && start;
    assign is_mul = (op_e'(op) == MUL);

    modport_alu_mul #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .ld      (accept && is_mul),
        .en      (state_q == S_MUL),
        .a       (A),
        .b       (B),
        .product (product)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state: leave IDLE only for multiply; leave MUL on the last count.
    always_comb begin
        state_d  = state_q;
        mul_last = 1'b0;
        case (state_q)
            S_IDLE: if (accept && is_mul) state_d = S_MUL;
            S_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_IDLE;
                    mul_last = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Edge counter for the MUL wait; parked at zero outside MUL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               cnt_q <= '0;
        else if (state_q == S_IDLE) cnt_q <= '0;
        else                        cnt_q <= cnt_q + 1'b1;
    end

    // Arm flag: cleared on accept, set at any edge that sees start low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    armed_q <= 1'b1;
        else if (!start) armed_q <= 1'b1;
        else if (accept) armed_q <= 1'b0;
    end

    // Output registers: done is a one-cycle pulse; result only moves with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done   <= 1'b0;
            result <= 16'h0000;
        end else begin
            done <= 1'b0;
            if (accept && !is_mul) begin
                done   <= 1'b1;
                result <= alu_single(A, B, op);
            end else if (mul_last) begin
                done   <= 1'b1;
                result <= product;
            end
        end
    end

endmodule

// File: tb/tb_modport_alu.sv
// Randomized + directed bench for modport_alu with a scoreboard monitor.
module tb_modport_alu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic [2:0]  op = 3'd0;
    logic        start = 1'b0;
    logic        done;
    logic [15:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    logic        prev_done = 1'b0;

    always #5 clk = ~clk;

    modport_alu #(.MUL_LAT(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode rules.
    function automatic logic [15:0] ref_res(input int a, input int b, input int o);
        int r;
        case (o)
            1:       r = a + b;
            2:       r = a & b;
            3:       r = a ^ b;
            4:       r = a * b;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            chk("dbl_done", 32'(prev_done), 32'd0);
            if (sb.size() == 0) chk("sb_depth", 32'(sb.size()), 32'd1);
            else                chk("sb_result", 32'(result), 32'(sb.pop_front()));
        end
        prev_done = done;
    end

    // Drive one request, hold start 'hold' cycles past done, then drop it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] o, input int hold);
        logic [15:0] exp;
        int          cyc;
        int          exp_lat;
        bit          got;
        exp     = ref_res(int'(a), int'(b), int'(o));
        exp_lat = (o == 3'd4) ? 3 : 1;
        sb.push_back(exp);
        A = a; B = b; op = o; start = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1;
            else begin
                A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
            end
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("result", 32'(result), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
            @(negedge clk);
            chk("sticky_done", 32'(done), 32'd0);
            chk("result_hold", 32'(result), 32'(exp));
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(8'hFF, 8'hFF, 3'd1, 3);   // add max, start held 3 cycles
        run_op(8'h02, 8'h03, 3'd1, 1);   // re-armed add -> 5
        run_op(8'hF0, 8'h3C, 3'd2, 1);   // and -> 0030
        run_op(8'hF0, 8'h3C, 3'd3, 1);   // xor -> 00CC
        run_op(8'h12, 8'h34, 3'd0, 1);   // nop
        run_op(8'hAB, 8'hCD, 3'd7, 1);   // reserved
        run_op(8'hFF, 8'hFF, 3'd4, 2);   // mul max -> FE01

        // Abort a multiply with reset; no done may follow.
        A = 8'hFF; B = 8'hFF; op = 3'd4; start = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_rst_done", 32'(done), 32'd0);
        chk("abort_rst_result", 32'(result), 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end

        run_op(8'h00, 8'h55, 3'd4, 1);   // mul by zero after reset
        run_op(8'h10, 8'h11, 3'd4, 1);

        for (int n = 0; n < 40; n++)
            run_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                   int'($urandom_range(1, 3)));

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
